// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
//   Shared definitions for the post-commit store buffer.
//   - sb_size_e   : access size encoding (word / byte). Decode, the ROB entry
//                   and the data cache use the same encoding.
//   - SB_DEPTH    : default number of buffer entries.
//   - SB_IDX_W    : default head/tail pointer width, log2(SB_DEPTH).
//   - sb_pick_byte: little-endian byte-lane extraction, zero-extended to 32 bits.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_IDX_W = 2;

   typedef enum logic {
      SB_WORD = 1'b0,
      SB_BYTE = 1'b1
   } sb_size_e;

   function automatic logic [31:0] sb_pick_byte(input logic [31:0] word,
                                                input logic [1:0]  lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return {24'b0, b};
   endfunction

endpackage

// File: rtl/store_buffer_match.sv
// -----------------------------------------------------------------------------
// store_buffer_match
//   Per-entry load/store comparator. One instance per buffer entry; the top
//   module performs the age-ordered priority select over all instances.
// Ports
//   entry_valid  in   entry holds a committed store
//   entry_addr   in   store byte address
//   entry_data   in   store data (byte stores carry the byte in [7:0])
//   entry_size   in   store size
//   ld_addr      in   load byte address
//   ld_size      in   load size
//   overlap      out  entry touches at least one byte the load reads
//   full_cover   out  entry supplies every byte the load reads
//   fwd_data     out  data the load would receive from this entry
// -----------------------------------------------------------------------------
module store_buffer_match
   import store_buffer_pkg::*;
(
   input  logic        entry_valid,
   input  logic [31:0] entry_addr,
   input  logic [31:0] entry_data,
   input  sb_size_e    entry_size,
   input  logic [31:0] ld_addr,
   input  sb_size_e    ld_size,
   output logic        overlap,
   output logic        full_cover,
   output logic [31:0] fwd_data
);

   logic same_word;
   logic disjoint_bytes;

   always_comb begin
      same_word      = (entry_addr[31:2] == ld_addr[31:2]);
      // Two byte accesses to different lanes of the same word do not interact.
      disjoint_bytes = (entry_size == SB_BYTE) && (ld_size == SB_BYTE) &&
                       (entry_addr[1:0] != ld_addr[1:0]);
      overlap        = entry_valid && same_word && !disjoint_bytes;
      // A byte store can only partially cover a word load.
      full_cover     = overlap && !((entry_size == SB_BYTE) && (ld_size == SB_WORD));

      if (entry_size == SB_BYTE) begin
         fwd_data = {24'b0, entry_data[7:0]};
      end else if (ld_size == SB_BYTE) begin
         fwd_data = sb_pick_byte(entry_data, ld_addr[1:0]);
      end else begin
         fwd_data = entry_data;
      end
   end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Post-commit store queue between the commit stage and the data cache.
//   Committed stores enter in program order and drain to dcache one per cycle
//   when it accepts. Loads look up the buffer combinationally and get either
//   forwarded data, a stall on partial overlap, or a miss (read dcache).
//   Entries are architecturally committed and are never squashed.
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   sb_in_valid/addr/data/byte         store enqueue from commit
//   sb_full, sb_empty, sb_count        occupancy status (registered count)
//   sb_out_valid/addr/data/byte        head entry presented to dcache
//   sb_out_ready                       dcache accepts head this cycle
//   sb_ld_valid/addr/byte              load lookup request
//   sb_ld_hit, sb_ld_data, sb_ld_stall lookup result (combinational)
// -----------------------------------------------------------------------------
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int IDX_W = SB_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sb_in_valid,
   input  logic [31:0]      sb_in_addr,
   input  logic [31:0]      sb_in_data,
   input  logic             sb_in_byte,
   output logic             sb_full,
   output logic             sb_empty,
   output logic [IDX_W:0]   sb_count,
   output logic             sb_out_valid,
   output logic [31:0]      sb_out_addr,
   output logic [31:0]      sb_out_data,
   output logic             sb_out_byte,
   input  logic             sb_out_ready,
   input  logic             sb_ld_valid,
   input  logic [31:0]      sb_ld_addr,
   input  logic             sb_ld_byte,
   output logic             sb_ld_hit,
   output logic [31:0]      sb_ld_data,
   output logic             sb_ld_stall
);

   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [IDX_W:0]   count;
   logic [DEPTH-1:0] valid;

   logic [31:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   sb_size_e         size_mem [DEPTH];

   logic             enq;
   logic             deq;

   logic [DEPTH-1:0] ovl;
   logic [DEPTH-1:0] cov;
   logic [31:0]      fwd [DEPTH];

   logic             hit_sel;
   logic             stall_sel;
   logic [31:0]      data_sel;
   logic [IDX_W-1:0] idx;

   assign sb_full      = (count == (IDX_W+1)'(DEPTH));
   assign sb_empty     = (count == '0);
   assign sb_count     = count;
   assign sb_out_valid = !sb_empty;
   assign sb_out_addr  = addr_mem[head];
   assign sb_out_data  = data_mem[head];
   assign sb_out_byte  = size_mem[head];

   // Full comes from the registered count, so a drain in the same cycle does
   // not open a slot for a store presented while full.
   assign enq = sb_in_valid && !sb_full;
   assign deq = sb_out_valid && sb_out_ready;

   // Control state: pointers, occupancy and per-entry valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (enq) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
         end
         if (deq) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry payload is not reset; the valid bits alone define occupancy.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[tail] <= sb_in_addr;
         data_mem[tail] <= sb_in_data;
         size_mem[tail] <= sb_size_e'(sb_in_byte);
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      store_buffer_match u_match (
         .entry_valid (valid[i]),
         .entry_addr  (addr_mem[i]),
         .entry_data  (data_mem[i]),
         .entry_size  (size_mem[i]),
         .ld_addr     (sb_ld_addr),
         .ld_size     (sb_size_e'(sb_ld_byte)),
         .overlap     (ovl[i]),
         .full_cover  (cov[i]),
         .fwd_data    (fwd[i])
      );
   end

   // Walk from oldest (head) to youngest; each later overlap overrides, so the
   // youngest overlapping entry decides. Byte stores to other lanes never set
   // ovl and therefore let older entries through.
   always_comb begin
      hit_sel   = 1'b0;
      stall_sel = 1'b0;
      data_sel  = '0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + IDX_W'(k);
         if (ovl[idx]) begin
            hit_sel   = cov[idx];
            stall_sel = !cov[idx];
            data_sel  = cov[idx] ? fwd[idx] : '0;
         end
      end
   end

   assign sb_ld_hit   = sb_ld_valid && hit_sel;
   assign sb_ld_stall = sb_ld_valid && stall_sel;
   assign sb_ld_data  = sb_ld_hit ? data_sel : '0;

endmodule
